// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter: ALU priority, queued LSU returns with kill and starvation stall
module wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_write_req,
    input  logic [4:0]  alu_write_addr,
    input  logic [31:0] alu_write_data,
    input  logic        lsu_write_req,
    input  logic [4:0]  lsu_write_addr,
    input  logic [31:0] lsu_write_data,
    output logic        lsu_ready,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        stall_req
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = 4;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  valid_next;
    logic [4:0]        ent_addr [DEPTH];
    logic [31:0]       ent_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;

    logic alu_hit;
    logic lsu_push;
    logic fifo_empty;
    logic head_live;
    logic pop;

    assign alu_hit    = alu_write_req && (alu_write_addr != 5'd0);
    assign fifo_empty = (count == '0);
    assign lsu_ready  = (count != CNT_W'(DEPTH));
    assign lsu_push   = lsu_write_req && lsu_ready && (lsu_write_addr != 5'd0);
    assign head_live  = !fifo_empty && ent_valid[head];
    // A killed head leaves without a write, so it pops even when the ALU owns the port.
    assign pop        = !fifo_empty && (!ent_valid[head] || !alu_hit);

    // Queued loads are older than the current ALU write, so a matching address makes them dead.
    always_comb begin
        valid_next = ent_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_hit && (ent_addr[i] == alu_write_addr)) begin
                valid_next[i] = 1'b0;
            end
        end
        if (lsu_push) begin
            valid_next[tail] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lsu_push) begin
            ent_addr[tail] <= lsu_write_addr;
            ent_data[tail] <= lsu_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid     <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            wait_cnt      <= '0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= 5'd0;
            rf_write_data <= 32'd0;
            stall_req     <= 1'b0;
        end else begin
            ent_valid <= valid_next;
            if (lsu_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(lsu_push) - CNT_W'(pop);

            if (pop || fifo_empty) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            stall_req <= (wait_cnt == WAIT_W'(MAX_WAIT)) && !pop && !fifo_empty;

            if (alu_hit) begin
                rf_write_en   <= 1'b1;
                rf_write_addr <= alu_write_addr;
                rf_write_data <= alu_write_data;
            end else if (head_live) begin
                rf_write_en   <= 1'b1;
                rf_write_addr <= ent_addr[head];
                rf_write_data <= ent_data[head];
            end else begin
                rf_write_en <= 1'b0;
            end
        end
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter for the RISC-V core. The register file has a single write port. Two units share it:
- the ALU writeback, which fires one cycle after issue and cannot be back-pressured;
- the load/store unit (LSU) load-return path, which can be back-pressured.

The block gives the ALU absolute priority and queues LSU returns in a small FIFO, draining them into idle port cycles. It also cancels queued loads overwritten by younger ALU writes and raises a stall request when a queued load starves. It sits between the ALU/LSU outputs and the register-file write port.

## Interface
- DEPTH, 2, LSU return FIFO entries (power of two, 2..8)
- MAX_WAIT, 4, cycles a FIFO head may wait before stall_req asserts (1..15)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- alu_write_req  in  1  ALU writeback valid (single-cycle per result, no handshake)
- alu_write_addr  in  5  ALU destination register
- alu_write_data  in  32  ALU result
- lsu_write_req  in  1  load data valid; accepted only when lsu_ready=1
- lsu_write_addr  in  5  load destination register
- lsu_write_data  in  32  load data
- lsu_ready  out  1  FIFO not full (combinational from occupancy count)
- rf_write_en  out  1  register-file write enable (registered)
- rf_write_addr  out  5  register-file write address (registered)
- rf_write_data  out  32  register-file write data (registered)
- stall_req  out  1  request to the issue stage to hold new instructions (registered)

## Operation
- Reset values: rf_write_en=0, rf_write_addr=0, rf_write_data=0, stall_req=0. The FIFO is empty (lsu_ready=1) and the wait counter is 0.
- x0 filter: a request with addr==0 is treated as absent.
  - An ALU write to x0 causes no rf write.
  - An LSU write to x0 is accepted (handshake completes) but is not enqueued.
- Arbitration is evaluated each cycle, in priority order:
  1. alu_write_req=1 (addr≠0): the output register loads the ALU addr/data with rf_write_en=1. The FIFO head is not dequeued.
  2. Otherwise, if the FIFO head is valid: the output register loads the head entry with rf_write_en=1 and the head is popped.
  3. Otherwise: rf_write_en=0. Addr/data hold their previous values.
- Enqueue: when lsu_write_req && lsu_ready && addr≠0, the entry is written at the FIFO tail. Enqueue and dequeue in the same cycle leave the count unchanged.
- Ordering rule: any entry already in the FIFO is older in program order than an ALU write arriving later.
  - When an ALU write to register A is accepted, every queued entry whose addr==A is killed (valid cleared) in the same cycle.
  - Killed entries are skipped when they reach the head: they pop without a write and without consuming the port.
  - An entry enqueued in the same cycle as the ALU write is not killed.
- Starvation guard: wait_cnt increments each cycle a valid head is present but not popped (ALU won the port).
  - It resets to 0 on a pop or when the FIFO is empty, and saturates at MAX_WAIT.
  - stall_req is set the cycle after wait_cnt reaches MAX_WAIT. It clears the cycle after that head is popped.
- The FIFO pointers wrap modulo DEPTH. The count width is clog2(DEPTH)+1.
- Asynchronous reset mid-operation discards all queued entries and clears every output immediately.

## Timing
- ALU path latency is 1: a request sampled at edge N gives rf_write_en=1 in cycle N+1.
- LSU path latency is at least 2: enqueue at edge N, head visible in cycle N+1, port write in cycle N+2 if the ALU is idle in cycle N+1.
- Throughput is one register-file write per cycle.
- lsu_ready falls in the same cycle the count reaches DEPTH. It does not account for a pop in that cycle; no fall-through when full.
- stall_req asserts exactly MAX_WAIT+1 cycles after the head first loses arbitration, assuming continuous ALU traffic.
- The kill comparison uses the current-cycle alu_write_addr against the stored entries and is registered into the valid bits at the edge.

## Test plan
- Idle ALU, LSU enqueues x5=0xDEADBEEF at cycle 0 → rf_write_en=1, rf_write_addr=5, rf_write_data=0xDEADBEEF in cycle 2; lsu_ready stays 1.
- ALU x3=0x11 and LSU x4=0x22 in the same cycle → cycle+1 writes x3=0x11, cycle+2 writes x4=0x22.
- DEPTH=2, continuous ALU writes, LSU pushes x6 and x7 → lsu_ready=0 after the second push. stall_req=1 at the (MAX_WAIT+1)th cycle of contention. When the ALU stops, the writes are x6 then x7, and stall_req clears the cycle after the x6 pop.
- LSU queues x8=0xAAAA, then the ALU writes x8=0xBBBB before the drain → only x8=0xBBBB appears at the port; the killed entry pops with no write.
- ALU write to x0 and LSU write to x0 → no rf_write_en, FIFO count stays 0, lsu_ready=1.
- reset_n pulled low with 2 entries queued and stall_req=1 → all outputs 0 immediately and lsu_ready=1; after release, no stale writes appear.
